// File: rtl/step_register.sv
// Programmable-step counter with reserved-code skip, load and clear.
// Overflow either wraps and halts until acknowledged, or saturates.
module step_register #(
  parameter int WIDTH    = 2,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter bit SKIP_EN  = 1'b1,
  parameter int SKIP_VAL = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic [WIDTH-1:0] step,
  input  logic             ovf_ack,
  output logic [WIDTH-1:0] value,
  output logic             ovf,
  output logic             ovf_pulse,
  output logic             load_err,
  output logic             halted
);

  typedef enum logic {RUN, HALT} state_e;

  localparam logic [WIDTH:0] MAXV  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] SKIPV = (WIDTH+1)'(SKIP_VAL);
  localparam logic [WIDTH:0] ONE   = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] SATV =
    (SKIP_EN && SKIP_VAL == MAX_VAL) ?
    WIDTH'(MAX_VAL-1) : WIDTH'(MAX_VAL);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             ovf_q, ovf_d;
  logic             pulse_q, pulse_d;
  logic             lerr_q, lerr_d;
  logic             halted_q;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] wrap;
  logic           over;
  logic           bad_load;

  always_comb begin
    sum = {1'b0, value_q} + {1'b0, step};
    if (SKIP_EN && sum == SKIPV) sum = sum + ONE;
    // wrap residue gets the skip re-applied once
    wrap = sum - MAXV - ONE;
    if (SKIP_EN && wrap == SKIPV) wrap = wrap + ONE;
    over = sum > MAXV;
    bad_load = ({1'b0, load_val} > MAXV) ||
               (SKIP_EN && {1'b0, load_val} == SKIPV);
  end

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    ovf_d   = ovf_q;
    pulse_d = 1'b0;
    lerr_d  = 1'b0;
    if (state_q == RUN) begin
      if (ovf_ack) ovf_d = 1'b0;
      if (clr) begin
        value_d = '0;
        ovf_d   = 1'b0;
      end else if (load) begin
        if (bad_load) lerr_d = 1'b1;
        else value_d = load_val;
      end else if (inc) begin
        if (!over) begin
          value_d = sum[WIDTH-1:0];
        end else begin
          ovf_d   = 1'b1;
          pulse_d = 1'b1;
          if (SATURATE) begin
            value_d = SATV;
          end else begin
            value_d = wrap[WIDTH-1:0];
            state_d = HALT;
          end
        end
      end
    end else begin
      if (clr) begin
        value_d = '0;
        ovf_d   = 1'b0;
        state_d = RUN;
      end else if (ovf_ack) begin
        ovf_d   = 1'b0;
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN;
      value_q  <= '0;
      ovf_q    <= 1'b0;
      pulse_q  <= 1'b0;
      lerr_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      ovf_q    <= ovf_d;
      pulse_q  <= pulse_d;
      lerr_q   <= lerr_d;
      halted_q <= (state_d == HALT);
    end
  end

  assign value     = value_q;
  assign ovf       = ovf_q;
  assign ovf_pulse = pulse_q;
  assign load_err  = lerr_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_step_register.sv
// Directed bench for step_register across four parameter sets.
// u0 defaults, u1 saturating W4, u2 W4 skip 5, u3 W4 skip 1.
module tb_step_register;

  logic clk = 1'b0;
  logic rst_n;
  logic clr_a  [4];
  logic load_a [4];
  logic inc_a  [4];
  logic ack_a  [4];
  logic [3:0] lv_a [4];
  logic [3:0] st_a [4];
  logic [1:0] lv0, st0, v0;
  logic [3:0] v1, v2, v3;
  logic ovf_a [4];
  logic pls_a [4];
  logic ler_a [4];
  logic hlt_a [4];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  step_register u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr_a[0]),
    .load(load_a[0]), .load_val(lv0),
    .inc(inc_a[0]), .step(st0), .ovf_ack(ack_a[0]),
    .value(v0), .ovf(ovf_a[0]), .ovf_pulse(pls_a[0]),
    .load_err(ler_a[0]), .halted(hlt_a[0])
  );

  step_register #(.WIDTH(4), .SKIP_EN(1'b0), .SATURATE(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr_a[1]),
    .load(load_a[1]), .load_val(lv_a[1]),
    .inc(inc_a[1]), .step(st_a[1]), .ovf_ack(ack_a[1]),
    .value(v1), .ovf(ovf_a[1]), .ovf_pulse(pls_a[1]),
    .load_err(ler_a[1]), .halted(hlt_a[1])
  );

  step_register #(.WIDTH(4), .SKIP_VAL(5)) u2 (
    .clk(clk), .rst_n(rst_n), .clr(clr_a[2]),
    .load(load_a[2]), .load_val(lv_a[2]),
    .inc(inc_a[2]), .step(st_a[2]), .ovf_ack(ack_a[2]),
    .value(v2), .ovf(ovf_a[2]), .ovf_pulse(pls_a[2]),
    .load_err(ler_a[2]), .halted(hlt_a[2])
  );

  step_register #(.WIDTH(4), .SKIP_VAL(1)) u3 (
    .clk(clk), .rst_n(rst_n), .clr(clr_a[3]),
    .load(load_a[3]), .load_val(lv_a[3]),
    .inc(inc_a[3]), .step(st_a[3]), .ovf_ack(ack_a[3]),
    .value(v3), .ovf(ovf_a[3]), .ovf_pulse(pls_a[3]),
    .load_err(ler_a[3]), .halted(hlt_a[3])
  );

  function automatic int gv(int d);
    case (d)
      0: gv = int'(v0);
      1: gv = int'(v1);
      2: gv = int'(v2);
      default: gv = int'(v3);
    endcase
  endfunction

  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_st(string tag, int d, int v, int o, int p, int h);
    check({tag, ".value"}, gv(d), v);
    check({tag, ".ovf"}, int'(ovf_a[d]), o);
    check({tag, ".pulse"}, int'(pls_a[d]), p);
    check({tag, ".halted"}, int'(hlt_a[d]), h);
  endtask

  task automatic idle();
    for (int k = 0; k < 4; k++) begin
      clr_a[k] = 1'b0; load_a[k] = 1'b0;
      inc_a[k] = 1'b0; ack_a[k] = 1'b0;
      lv_a[k] = '0; st_a[k] = '0;
    end
    lv0 = '0;
    st0 = '0;
  endtask

  task automatic cmd(int d, bit c, bit l, logic [3:0] lv,
                     bit i, logic [3:0] s, bit a);
    idle();
    clr_a[d] = c; load_a[d] = l; inc_a[d] = i; ack_a[d] = a;
    lv_a[d] = lv; st_a[d] = s;
    if (d == 0) begin
      lv0 = lv[1:0];
      st0 = s[1:0];
    end
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_st("rst0", 0, 0, 0, 0, 0);
    check("rst0.lerr", int'(ler_a[0]), 0);
    chk_st("rst3", 3, 0, 0, 0, 0);

    // default counting 0->1->2->0 with wrap halt
    cmd(0, 0, 0, 0, 1, 1, 0); chk_st("inc1", 0, 1, 0, 0, 0);
    cmd(0, 0, 0, 0, 1, 1, 0); chk_st("inc2", 0, 2, 0, 0, 0);
    cmd(0, 0, 0, 0, 1, 1, 0); chk_st("inc3", 0, 0, 1, 1, 1);
    cmd(0, 0, 0, 0, 1, 1, 0); chk_st("inc4", 0, 0, 1, 0, 1);
    cmd(0, 0, 0, 0, 0, 0, 1); chk_st("ack", 0, 0, 0, 0, 0);
    cmd(0, 0, 1, 3, 0, 0, 0);
    check("ld3.lerr", int'(ler_a[0]), 1);
    check("ld3.value", gv(0), 0);
    cmd(0, 0, 1, 2, 0, 0, 0);
    check("ld2.lerr", int'(ler_a[0]), 0);
    check("ld2.value", gv(0), 2);
    cmd(0, 0, 0, 0, 1, 0, 0); chk_st("step0", 0, 2, 0, 0, 0);

    // priority
    cmd(0, 1, 1, 2, 1, 1, 0); check("clrpri", gv(0), 0);
    cmd(0, 0, 1, 1, 1, 1, 0); check("ldpri", gv(0), 1);
    cmd(0, 0, 0, 0, 1, 3, 0); chk_st("ovf2", 0, 0, 1, 1, 1);
    cmd(0, 0, 1, 2, 0, 0, 0);
    check("hltld.lerr", int'(ler_a[0]), 0);
    check("hltld.value", gv(0), 0);
    cmd(0, 1, 0, 0, 0, 0, 0); chk_st("hltclr", 0, 0, 0, 0, 0);

    // saturating instance
    cmd(1, 0, 1, 14, 0, 0, 0); check("s.ld", gv(1), 14);
    cmd(1, 0, 0, 0, 1, 5, 0); chk_st("s.inc5", 1, 15, 1, 1, 0);
    cmd(1, 0, 0, 0, 1, 1, 0); chk_st("s.inc1", 1, 15, 1, 1, 0);
    cmd(1, 0, 0, 0, 0, 0, 1); chk_st("s.ack", 1, 15, 0, 0, 0);
    cmd(1, 0, 0, 0, 1, 1, 1); chk_st("s.ackovf", 1, 15, 1, 1, 0);

    // skip 5 wrap instance
    cmd(2, 0, 1, 3, 0, 0, 0); check("k5.ld", gv(2), 3);
    cmd(2, 0, 0, 0, 1, 2, 0); chk_st("k5.skip", 2, 6, 0, 0, 0);
    cmd(2, 0, 1, 5, 0, 0, 0);
    check("k5.ldskip.lerr", int'(ler_a[2]), 1);
    check("k5.ldskip.value", gv(2), 6);
    cmd(2, 0, 1, 14, 0, 0, 0); check("k5.ld14", gv(2), 14);
    cmd(2, 0, 0, 0, 1, 3, 0); chk_st("k5.wrap", 2, 1, 1, 1, 1);

    // skip 1 wrap instance: post-wrap skip
    cmd(3, 0, 1, 14, 0, 0, 0); check("k1.ld14", gv(3), 14);
    cmd(3, 0, 0, 0, 1, 3, 0); chk_st("k1.wrap", 3, 2, 1, 1, 1);
    cmd(3, 0, 0, 0, 1, 1, 0); chk_st("k1.hltinc", 3, 2, 1, 0, 1);

    // reset glitch between edges must not act
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    chk_st("glitch.now", 3, 2, 1, 0, 1);
    @(posedge clk);
    #1;
    chk_st("glitch.edge", 3, 2, 1, 0, 1);

    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_st("hltrst", 3, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
